// File: rtl/dart_scorer.sv
// dart_scorer
//   Sequential dart-game scorer. Throws arrive as (X, Y) cell coordinates over
//   a valid/ready handshake. Each throw is scored with a square-ring board
//   model and added, with saturation, to the current player's total. Turns
//   rotate every THROWS throws and rounds advance after the last player. When
//   the final throw of the game is accepted, one RESOLVE cycle picks the
//   winner. The result is then held in DONE.
//
// Configuration macro: DART_BONUS_EN
//   defined   -> a centre-cell hit (r = 0) scores 2*RINGS
//   undefined -> a centre-cell hit scores RINGS
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (returns to IDLE)
//   start        begin a new game (honoured in IDLE/DONE only)
//   throw_valid  throw presented on X/Y
//   X, Y         throw column / row
//   throw_ready  high only in PLAY
//   last_score   points of the most recently accepted throw
//   cur_player   player whose throw is expected
//   cur_round    current round index
//   total_flat   player totals, player p at [p*TOT_W +: TOT_W]
//   game_over    high in DONE
//   winner       lowest player index holding the top total
//   tie          top total shared by two or more players
module dart_scorer #(
    parameter int COORD_W   = 2,
    parameter int RINGS     = 2,
    parameter int N_PLAYERS = 2,
    parameter int THROWS    = 3,
    parameter int ROUNDS    = 3,
    parameter int TOT_W     = 8,
    localparam int SCORE_W  = $clog2(2*RINGS+1),
    localparam int PL_W     = $clog2(N_PLAYERS),
    localparam int RND_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       throw_valid,
    input  logic [COORD_W-1:0]         X,
    input  logic [COORD_W-1:0]         Y,
    output logic                       throw_ready,
    output logic [SCORE_W-1:0]         last_score,
    output logic [PL_W-1:0]            cur_player,
    output logic [RND_W-1:0]           cur_round,
    output logic [N_PLAYERS*TOT_W-1:0] total_flat,
    output logic                       game_over,
    output logic [PL_W-1:0]            winner,
    output logic                       tie
);

    localparam int THR_W = (THROWS > 1) ? $clog2(THROWS) : 1;
    localparam logic [COORD_W-1:0] CTR = COORD_W'(1 << (COORD_W-1));

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_RESOLVE, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [TOT_W-1:0]   total_q [N_PLAYERS];
    logic [TOT_W-1:0]   total_d [N_PLAYERS];
    logic [SCORE_W-1:0] last_score_q, last_score_d;
    logic [PL_W-1:0]    player_q, player_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [THR_W-1:0]   throw_q, throw_d;
    logic [PL_W-1:0]    winner_q, winner_d;
    logic               tie_q, tie_d;

    // Board model: Chebyshev distance from the centre cell selects the ring.
    logic [COORD_W-1:0] dx, dy, r;
    logic [SCORE_W-1:0] score_c;
    logic [TOT_W:0]     sum_c;

    always_comb begin
        dx = (X >= CTR) ? X - CTR : CTR - X;
        dy = (Y >= CTR) ? Y - CTR : CTR - Y;
        r  = (dx > dy) ? dx : dy;
        if (int'(r) < RINGS) score_c = SCORE_W'(RINGS - int'(r));
        else                 score_c = '0;
`ifdef DART_BONUS_EN
        if (r == '0) score_c = SCORE_W'(2*RINGS);
`endif
        // One extra bit catches overflow so the total can saturate.
        sum_c = {1'b0, total_q[player_q]} + (TOT_W+1)'(score_c);
    end

    // Winner search: a strictly larger total restarts the tie flag, and an
    // equal total only marks a tie, so the lowest index keeps the win.
    logic [TOT_W-1:0] best_c;
    logic [PL_W-1:0]  win_c;
    logic             tie_c;

    always_comb begin
        best_c = total_q[0];
        win_c  = '0;
        tie_c  = 1'b0;
        for (int p = 1; p < N_PLAYERS; p++) begin
            if (total_q[p] > best_c) begin
                best_c = total_q[p];
                win_c  = PL_W'(p);
                tie_c  = 1'b0;
            end else if (total_q[p] == best_c) begin
                tie_c = 1'b1;
            end
        end
    end

    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        total_d      = total_q;
        last_score_d = last_score_q;
        player_d     = player_q;
        round_d      = round_q;
        throw_d      = throw_q;
        winner_d     = winner_q;
        tie_d        = tie_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_PLAY;
                    last_score_d = '0;
                    player_d     = '0;
                    round_d      = '0;
                    throw_d      = '0;
                    winner_d     = '0;
                    tie_d        = 1'b0;
                    for (int p = 0; p < N_PLAYERS; p++) total_d[p] = '0;
                end
            end
            S_PLAY: begin
                if (throw_valid) begin
                    last_score_d      = score_c;
                    total_d[player_q] = sum_c[TOT_W] ? '1 : sum_c[TOT_W-1:0];
                    if (throw_q == THR_W'(THROWS-1)) begin
                        throw_d = '0;
                        if (player_q == PL_W'(N_PLAYERS-1)) begin
                            player_d = '0;
                            // The last round stays visible after the final throw.
                            if (round_q == RND_W'(ROUNDS-1)) state_d = S_RESOLVE;
                            else                             round_d = round_q + 1'b1;
                        end else begin
                            player_d = player_q + 1'b1;
                        end
                    end else begin
                        throw_d = throw_q + 1'b1;
                    end
                end
            end
            S_RESOLVE: begin
                winner_d = win_c;
                tie_d    = tie_c;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            last_score_q <= '0;
            player_q     <= '0;
            round_q      <= '0;
            throw_q      <= '0;
            winner_q     <= '0;
            tie_q        <= 1'b0;
            for (int p = 0; p < N_PLAYERS; p++) total_q[p] <= '0;
        end else begin
            state_q      <= state_d;
            last_score_q <= last_score_d;
            player_q     <= player_d;
            round_q      <= round_d;
            throw_q      <= throw_d;
            winner_q     <= winner_d;
            tie_q        <= tie_d;
            total_q      <= total_d;
        end
    end

    always_comb begin
        for (int p = 0; p < N_PLAYERS; p++) total_flat[p*TOT_W +: TOT_W] = total_q[p];
    end

    assign throw_ready = (state_q == S_PLAY);
    assign game_over   = (state_q == S_DONE);
    assign last_score  = last_score_q;
    assign cur_player  = player_q;
    assign cur_round   = round_q;
    assign winner      = winner_q;
    assign tie         = tie_q;

endmodule
